// File: rtl/dt_pkg.sv
// Shared constants and the arbiter state type for the distance-transform result-RAM datapath.
package dt_pkg;
   localparam int IMG_W    = 128;
   localparam int AW       = 14;
   localparam int DW       = 8;
   localparam int NREQ     = 3;
   localparam int REQ_LOAD = 0;
   localparam int REQ_FWD  = 1;
   localparam int REQ_BWD  = 2;

   typedef enum logic [1:0] {ARB_IDLE, ARB_OPEN, ARB_LOCK} arb_state_e;
endpackage

// File: rtl/dt_res_arbiter_if.sv
// Requester-side command / read-return bundle of the result-RAM arbiter.
interface dt_res_arbiter_if #(
   parameter int NREQ = dt_pkg::NREQ,
   parameter int AW   = dt_pkg::AW,
   parameter int DW   = dt_pkg::DW
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ-1:0]    lock;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;

   modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dt_rr_pick.sv
// Rotating-priority picker: first requester after i_last (mod NREQ) wins, one-hot out.
module dt_rr_pick #(
   parameter int NREQ = 3,
   parameter int LW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [LW-1:0]   i_last,
   output logic [NREQ-1:0] o_win
);
   logic [LW-1:0] w_idx;

   // Walk from farthest to nearest so the nearest requester overwrites the rest.
   always_comb begin
      o_win = '0;
      w_idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         w_idx = LW'((int'(i_last) + k) % NREQ);
         if (i_req[w_idx]) o_win = NREQ'(1) << w_idx;
      end
   end
endmodule

// File: rtl/dt_res_arbiter.sv
// Round-robin arbiter with lock for the single-port result RAM; 2-cycle read return.
// Optional DT_RES_ARB_STAT_EN adds per-requester saturating stall counters.
module dt_res_arbiter import dt_pkg::*; #(
   parameter int NREQ = dt_pkg::NREQ,
   parameter int AW   = dt_pkg::AW,
   parameter int DW   = dt_pkg::DW
) (
   input  logic                 clk,
   input  logic                 reset,
   dt_res_arbiter_if.slave      bus,
   output logic                 res_rd,
   output logic                 res_wr,
   output logic [AW-1:0]        res_addr,
   output logic [DW-1:0]        res_do,
   input  logic [DW-1:0]        res_di,
   output logic                 busy
`ifdef DT_RES_ARB_STAT_EN
   ,
   output logic [NREQ*16-1:0]   stall_cnt
`endif
);
   localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e                r_state, w_state_nxt;
   logic [LW-1:0]             r_last, w_win_idx;
   logic [NREQ-1:0]           w_pick, w_gnt;
   logic                      w_any;
   logic                      r_rd, r_wr, r_busy;
   logic [AW-1:0]             r_addr;
   logic [DW-1:0]             r_do;
   logic [2:1][NREQ-1:0]      r_vld_pipe;

   dt_rr_pick #(.NREQ(NREQ), .LW(LW)) u_pick (
      .i_req  (bus.req),
      .i_last (r_last),
      .o_win  (w_pick)
   );

   // While locked only the owner (last winner) can be served; its req=0 releases.
   always_comb begin
      w_gnt = w_pick;
      if (r_state == ARB_LOCK)
         w_gnt = bus.req[r_last] ? (NREQ'(1) << r_last) : '0;
      w_any     = |w_gnt;
      w_win_idx = r_last;
      for (int k = 0; k < NREQ; k++)
         if (w_gnt[k]) w_win_idx = LW'(k);
      w_state_nxt = ARB_IDLE;
      if (w_any) w_state_nxt = bus.lock[w_win_idx] ? ARB_LOCK : ARB_OPEN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ARB_IDLE;
         r_last     <= LW'(NREQ - 1);
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_busy     <= 1'b0;
         r_addr     <= '0;
         r_do       <= '0;
         r_vld_pipe <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd       <= w_any & ~bus.we[w_win_idx];
         r_wr       <= w_any &  bus.we[w_win_idx];
         r_busy     <= w_any | (w_state_nxt == ARB_LOCK);
         r_vld_pipe <= {r_vld_pipe[1], w_gnt & ~bus.we};
         if (w_any) begin
            r_last <= w_win_idx;
            r_addr <= bus.addr[w_win_idx*AW +: AW];
            r_do   <= bus.wdata[w_win_idx*DW +: DW];
         end
      end
   end

   assign bus.gnt    = w_gnt;
   assign bus.rvalid = r_vld_pipe[2];
   assign bus.rdata  = res_di;
   assign res_rd     = r_rd;
   assign res_wr     = r_wr;
   assign res_addr   = r_addr;
   assign res_do     = r_do;
   assign busy       = r_busy;

`ifdef DT_RES_ARB_STAT_EN
   logic [NREQ-1:0][15:0] r_stall;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (reset)
            r_stall[i] <= '0;
         else if (bus.req[i] && !w_gnt[i] && r_stall[i] != 16'hFFFF)
            r_stall[i] <= r_stall[i] + 16'd1;
      end
   end

   assign stall_cnt = r_stall;
`endif
endmodule

// File: tb/tb_dt_res_arbiter.sv
// Bench for dt_res_arbiter: directed scenarios, then random traffic against a queue/array model.
module tb_dt_res_arbiter;
   import dt_pkg::*;
   localparam int N = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dt_res_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus();
   logic          res_rd, res_wr, busy;
   logic [AW-1:0] res_addr;
   logic [DW-1:0] res_do, res_di;
`ifdef DT_RES_ARB_STAT_EN
   logic [N*16-1:0] stall_cnt;
`endif

   dt_res_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus.slave),
      .res_rd   (res_rd),
      .res_wr   (res_wr),
      .res_addr (res_addr),
      .res_do   (res_do),
      .res_di   (res_di),
      .busy     (busy)
`ifdef DT_RES_ARB_STAT_EN
      ,
      .stall_cnt(stall_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] init_val(input int a);
      return 8'((a * 7) + 3);
   endfunction

   // Single-port RAM: one-cycle read latency.
   logic [7:0] ram [16384];
   initial begin
      for (int i = 0; i < 16384; i++) ram[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (res_wr) ram[res_addr] = res_do;
         if (res_rd) res_di <= ram[res_addr];
      end
   end

   // Reference model: pointer, lock owner, shadow memory, expected outputs one/two cycles ahead.
   logic [7:0]  shadow [16384];
   int          m_last = N - 1;
   int          m_owner = -1;
   logic        exp_rd = 1'b0, exp_wr = 1'b0, exp_busy = 1'b0;
   logic [13:0] exp_addr = '0;
   logic [7:0]  exp_do = '0, exp_rdat1 = '0, exp_rdat = '0;
   logic [2:0]  exp_rv1 = '0, exp_rv = '0;
   int          exp_stall [N];

   initial begin
      logic [2:0] eg;
      int         w;
      for (int i = 0; i < 16384; i++) shadow[i] = init_val(i);
      for (int i = 0; i < N; i++) exp_stall[i] = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         eg = '0;
         if (m_owner >= 0) begin
            if (bus.req[m_owner]) eg[m_owner] = 1'b1;
         end else begin
            for (int k = 1; k <= N; k++) begin
               if (eg == 3'b000 && bus.req[(m_last + k) % N]) eg[(m_last + k) % N] = 1'b1;
            end
         end
         chk("gnt", bus.gnt, eg);
         chk("res_rd", res_rd, exp_rd);
         chk("res_wr", res_wr, exp_wr);
         chk("busy", busy, exp_busy);
         chk("res_addr", res_addr, exp_addr);
         chk("res_do", res_do, exp_do);
         chk("rvalid", bus.rvalid, exp_rv);
         if (exp_rv != 3'b000) chk("rdata", bus.rdata, exp_rdat);
`ifdef DT_RES_ARB_STAT_EN
         for (int i = 0; i < N; i++) chk("stall_cnt", stall_cnt[i*16 +: 16], 64'(exp_stall[i]));
`endif
         if (reset) begin
            m_last = N - 1; m_owner = -1;
            exp_rd = 0; exp_wr = 0; exp_busy = 0; exp_addr = '0; exp_do = '0;
            exp_rv1 = '0; exp_rv = '0;
            for (int i = 0; i < N; i++) exp_stall[i] = 0;
         end else begin
            for (int i = 0; i < N; i++)
               if (bus.req[i] && !eg[i] && exp_stall[i] < 16'hFFFF) exp_stall[i]++;
            exp_rv = exp_rv1;
            exp_rdat = exp_rdat1;
            exp_rv1 = '0;
            if (eg != 3'b000) begin
               w = 0;
               for (int i = 0; i < N; i++) if (eg[i]) w = i;
               exp_addr = bus.addr[w*AW +: AW];
               exp_do   = bus.wdata[w*DW +: DW];
               exp_rd   = !bus.we[w];
               exp_wr   = bus.we[w];
               exp_busy = 1'b1;
               if (bus.we[w]) shadow[exp_addr] = exp_do;
               else begin exp_rv1 = eg; exp_rdat1 = shadow[exp_addr]; end
               m_last  = w;
               m_owner = bus.lock[w] ? w : -1;
            end else begin
               exp_rd = 0; exp_wr = 0; exp_busy = 0;
               m_owner = -1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic set_req(input int i, input bit r, input bit w, input bit l,
                          input logic [13:0] a, input logic [7:0] d);
      bus.req[i] = r; bus.we[i] = w; bus.lock[i] = l;
      bus.addr[i*AW +: AW] = a; bus.wdata[i*DW +: DW] = d;
   endtask

   task automatic idle_all();
      bus.req = '0; bus.we = '0; bus.lock = '0;
   endtask

   logic [2:0]  t1_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
   logic [13:0] ker    [5] = '{14'd0, 14'd1, 14'd2, 14'd128, 14'd129};

   initial begin
      logic [2:0] g;
      idle_all(); bus.addr = '0; bus.wdata = '0;
      repeat (3) tick();
      reset = 0;
      chk("reset_busy", busy, 1'b0);
      chk("reset_res_rd", res_rd, 1'b0);

      // all three read continuously: strict rotation, rvalid two cycles behind
      for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 14'(i * 16), 8'h00);
      for (int k = 0; k < 6; k++) begin
         #1 chk("t1_gnt", bus.gnt, t1_exp[k]);
         if (k >= 2) chk("t1_rvalid", bus.rvalid, t1_exp[k-2]);
         tick();
      end
      idle_all(); tick(); tick();

      // write then read same address on consecutive cycles
      set_req(1, 1, 1, 0, 14'd129, 8'd5);
      #1 chk("t2_wgnt", bus.gnt, 3'b010);
      tick();
      bus.req[1] = 0; set_req(2, 1, 0, 0, 14'd129, 8'd0);
      #1 chk("t2_rgnt", bus.gnt, 3'b100);
      chk("t2_res_wr", res_wr, 1'b1);
      chk("t2_res_addr", res_addr, 14'd129);
      tick();
      idle_all();
      #1 chk("t2_res_rd", res_rd, 1'b1);
      tick();
      #1 chk("t2_rvalid", bus.rvalid, 3'b100);
      chk("t2_rdata", bus.rdata, 8'd5);
      tick();

      // locked 5-read window from requester 1 while 0 and 2 wait
      set_req(0, 1, 0, 0, 14'd7, 8'd0);
      #1 chk("t3_pre", bus.gnt, 3'b001);
      tick();
      set_req(2, 1, 0, 0, 14'd4, 8'd0);
      for (int k = 0; k < 5; k++) begin
         set_req(1, 1, 0, k < 4, ker[k], 8'd0);
         #1 chk("t3_lock_gnt", bus.gnt, 3'b010);
         tick();
      end
      bus.req[1] = 0;
      #1 chk("t3_after_lock", bus.gnt, 3'b100);
      tick();
      idle_all(); tick(); tick();

      // owner drops req while locked: defensive release
      set_req(1, 1, 0, 1, 14'd50, 8'd0);
      #1 chk("t4_owner", bus.gnt, 3'b010);
      tick();
      idle_all(); set_req(0, 1, 0, 0, 14'd60, 8'd0);
      #1 chk("t4_locked", bus.gnt, 3'b000);
      tick();
      #1 chk("t4_release", bus.gnt, 3'b001);
      tick();
      idle_all(); tick(); tick();

      // reset the cycle after a read is accepted
      set_req(0, 1, 0, 0, 14'd300, 8'd0);
      #1 chk("t5_gnt", bus.gnt, 3'b001);
      tick();
      reset = 1; idle_all();
      #1 chk("t5_rd_inflight", res_rd, 1'b1);
      tick();
      reset = 0;
      #1 chk("t5_rd_cleared", res_rd, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_rvalid", bus.rvalid, 3'b000);
      tick();
      bus.req = '1;
      #1 chk("t5_first_gnt", bus.gnt, 3'b001);
      tick();
      idle_all(); tick();

      // requester 2 stalled 10 cycles behind lock owner 1
      reset = 1; tick(); reset = 0;
      set_req(1, 1, 0, 1, 14'd10, 8'd0);
      #1 chk("t6_owner", bus.gnt, 3'b010);
      tick();
      set_req(2, 1, 0, 0, 14'd11, 8'd0);
      for (int k = 0; k < 10; k++) begin
         bus.lock[1] = (k < 9);
         #1 chk("t6_lock_gnt", bus.gnt, 3'b010);
         tick();
      end
      bus.req[1] = 0;
      #1 chk("t6_gnt2", bus.gnt, 3'b100);
`ifdef DT_RES_ARB_STAT_EN
      chk("t6_stall2", stall_cnt[2*16 +: 16], 16'd10);
`endif
      tick();
      idle_all(); tick();

      // random traffic; requesters hold commands until granted
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); g = bus.gnt;
         @(posedge clk); #1;
         if ($urandom_range(0, 399) == 0) begin
            reset = 1; idle_all();
         end else begin
            reset = 0;
            for (int i = 0; i < N; i++) begin
               if (!bus.req[i] || g[i])
                  set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) != 0 ? 14'($urandom_range(0, 7)) : 14'($urandom),
                          8'($urandom));
            end
         end
      end
      reset = 0; idle_all();
      repeat (5) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
